// File: rtl/aes_uart_pkg.sv
// Shared constants and types for the UART-to-AES receive path.
//   AES_BLOCK_BYTES   : bytes per AES block
//   UART_CLKS_PER_BIT : uart_rx oversampling divider at 100 MHz
//   RX_IDLE_BIT_TIMES : idle bit-times before a partial block is abandoned
//   asm_state_t       : block assembler state encoding
package aes_uart_pkg;

  localparam int unsigned AES_BLOCK_BYTES   = 16;
  localparam int unsigned UART_CLKS_PER_BIT = 868;
  localparam int unsigned RX_IDLE_BIT_TIMES = 20;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/rx_idle_timer.sv
// Idle timer for partial receive blocks.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : force the timer back to 0 (has priority over run)
//   run          : count this cycle as idle
//   expire       : asserted on the idle cycle where the timer reaches TIMEOUT_CYCLES-1
module rx_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 17360
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] timer_q;

  // Expiry is qualified by run so a byte on the expiry cycle always wins.
  assign expire = run && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle cycle counter; restarts after expiry so it never wraps.
  always_ff @(posedge clock) begin
    if (reset || clear || expire) begin
      timer_q <= '0;
    end else if (run) begin
      timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: rtl/rx_block_assembler.sv
// Packs the uart_rx byte stream into fixed-size blocks for the AES core and
// presents each block with a valid/ready handshake, holding it stable until
// accepted. The first byte received lands in the MSBs of o_block_data.
// Optional feature: define RX_BLOCK_TIMEOUT_EN to drop a partial block after
// TIMEOUT_CYCLES idle cycles (o_timeout pulses); otherwise o_timeout is 0 and a
// partial block waits indefinitely.
//   clock, reset   : system clock, synchronous active-high reset
//   i_rx_dv        : 1-cycle byte strobe from uart_rx
//   i_rx_byte      : received byte, valid with i_rx_dv
//   o_block_valid  : o_block_data holds a complete block
//   i_block_ready  : downstream accepts the block
//   o_block_data   : assembled block
//   o_byte_count   : bytes collected in the current block
//   o_overrun      : 1-cycle pulse, a byte was dropped while a block waited
//   o_timeout      : 1-cycle pulse, a partial block was discarded
module rx_block_assembler
  import aes_uart_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = AES_BLOCK_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = RX_IDLE_BIT_TIMES * UART_CLKS_PER_BIT
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_rx_dv,
  input  logic [7:0]                       i_rx_byte,
  output logic                             o_block_valid,
  input  logic                             i_block_ready,
  output logic [8*BLOCK_BYTES-1:0]         o_block_data,
  output logic [$clog2(BLOCK_BYTES+1)-1:0] o_byte_count,
  output logic                             o_overrun,
  output logic                             o_timeout
);

  localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned DW = 8 * BLOCK_BYTES;

  // Elaboration-time guard on the supported configuration range.
  if (BLOCK_BYTES < 2 || BLOCK_BYTES > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("rx_block_assembler: BLOCK_BYTES must be 2..32 and TIMEOUT_CYCLES >= 2");
  end

  asm_state_t    state_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          overrun_q;
  logic          timer_expire;

`ifdef RX_BLOCK_TIMEOUT_EN
  logic timer_clear;
  logic timer_run;
  logic timeout_q;

  // Only a non-empty block that is still collecting can age.
  assign timer_run   = (state_q == COLLECT) && (count_q != '0) && !i_rx_dv;
  assign timer_clear = i_rx_dv || (state_q != COLLECT) || (count_q == '0);

  rx_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .run    (timer_run),
    .expire (timer_expire)
  );

  // Timeout pulse lands on the same cycle the count drops to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timer_expire;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timer_expire = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  // Collect/hold state machine with byte placement and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (i_rx_dv) begin
            for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
              if (count_q == CW'(i)) begin
                data_q[8*(BLOCK_BYTES-i)-1 -: 8] <= i_rx_byte;
              end
            end
            if (count_q == CW'(BLOCK_BYTES - 1)) begin
              state_q <= FULL;
              valid_q <= 1'b1;
              count_q <= CW'(BLOCK_BYTES);
            end else begin
              count_q <= count_q + CW'(1);
            end
          end else if (timer_expire) begin
            count_q <= '0;
          end
        end
        FULL: begin
          if (i_block_ready) begin
            state_q <= COLLECT;
            valid_q <= 1'b0;
            // A byte arriving on the handshake cycle starts the next block.
            if (i_rx_dv) begin
              data_q[DW-1 -: 8] <= i_rx_byte;
              count_q           <= CW'(1);
            end else begin
              count_q <= '0;
            end
          end else if (i_rx_dv) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= COLLECT;
          valid_q <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign o_block_valid = valid_q;
  assign o_block_data  = data_q;
  assign o_byte_count  = count_q;
  assign o_overrun     = overrun_q;

endmodule
